gf2m_409_reduce: RTL and testbench



---
 rtl/gf2m_409_pkg.sv | 9 +
 rtl/gf2m_fold_step.sv | 13 +
 rtl/gf2m_409_reduce.sv | 56 +++++
 tb/tb_gf2m_409_reduce.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/gf2m_409_pkg.sv
// gf2m_409_pkg: shared field constants, operand types and reduction FSM states
package gf2m_409_pkg;
  localparam int M = 409;
  localparam int K = 87;
  localparam int W = 2 * M - 1;
  typedef logic [W-1:0] prod_t;
  typedef logic [M-1:0] elem_t;
  typedef enum logic [1:0] {IDLE, FOLD1, FOLD2, OUT} state_t;
endpackage

// File: rtl/gf2m_fold_step.sv
// gf2m_fold_step: one combinational fold of the high half using x^M = x^K + 1
module gf2m_fold_step #(
  parameter int M = gf2m_409_pkg::M,
  parameter int K = gf2m_409_pkg::K,
  parameter int W = 2 * M - 1
) (
  input  logic [W-1:0] acc,
  output logic [W-1:0] folded
);
  logic [W-M-1:0] h;
  assign h = acc[W-1:M];
  assign folded = {{(W-M){1'b0}}, acc[M-1:0]} ^ {{M{1'b0}}, h} ^ ({{M{1'b0}}, h} << K);
endmodule

// File: rtl/gf2m_409_reduce.sv
// gf2m_409_reduce: constant-time two-fold reduction of an 817-bit product mod x^409+x^87+1
module gf2m_409_reduce #(
  parameter int M = gf2m_409_pkg::M,
  parameter int K = gf2m_409_pkg::K,
  parameter int W = 2 * M - 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] c_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [M-1:0] r_out
);
  import gf2m_409_pkg::*;
  state_t state;
  logic [W-1:0] acc;
  logic [W-1:0] folded;
  logic [M-1:0] r_q;
  gf2m_fold_step #(.M(M), .K(K), .W(W)) u_fold (.acc(acc), .folded(folded));
  assign in_ready = (state == IDLE) | ((state == OUT) & out_ready);
  assign out_valid = state == OUT;
  assign r_out = r_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      acc <= '0;
      r_q <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          acc <= c_in;
          state <= FOLD1;
        end
        FOLD1: begin
          acc <= folded;
          state <= FOLD2;
        end
        FOLD2: begin
          // two folds always clear the high half because K < M/2
          assert (folded[W-1:M] == '0);
          r_q <= folded[M-1:0];
          state <= OUT;
        end
        OUT: if (out_ready) begin
          if (in_valid) begin
            acc <= c_in;
            state <= FOLD1;
          end else state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_gf2m_409_reduce.sv
// tb_gf2m_409_reduce: directed vectors, random back-to-back stream, backpressure and reset checks
module tb_gf2m_409_reduce;
  import gf2m_409_pkg::*;
  logic clk = 0;
  logic rst_n = 0;
  logic in_valid = 0;
  logic in_ready;
  prod_t c_in = '0;
  logic out_valid;
  logic out_ready = 0;
  elem_t r_out;
  int errors = 0;
  int checks = 0;

  gf2m_409_reduce dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .c_in(c_in), .out_valid(out_valid), .out_ready(out_ready), .r_out(r_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    prod_t c;
    elem_t r;
  } vec_t;
  vec_t vecs[4];

  function automatic prod_t bit_p(input int i);
    prod_t p;
    p = '0;
    p[i] = 1'b1;
    return p;
  endfunction

  // schoolbook long division by f(x), one leading term at a time
  function automatic elem_t ref_mod(input prod_t c);
    prod_t a;
    a = c;
    for (int i = W - 1; i >= M; i--)
      if (a[i]) begin
        a[i] = 1'b0;
        a[i-M+K] = ~a[i-M+K];
        a[i-M] = ~a[i-M];
      end
    return a[M-1:0];
  endfunction

  function automatic prod_t rand_p();
    prod_t p;
    p = '0;
    for (int i = 0; i < 26; i++) p = (p << 32) | prod_t'($urandom);
    return p;
  endfunction

  task automatic chk(input string name, input elem_t act, input elem_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_out(input string name, output int lat);
    lat = 1;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    if (!out_valid) chk({name, " timeout"}, 0, 1);
  endtask

  task automatic run_one(input string name, input prod_t c, input elem_t exp);
    int lat;
    chk({name, " in_ready"}, elem_t'(in_ready), 1);
    in_valid = 1;
    c_in = c;
    tick();
    in_valid = 0;
    c_in = rand_p();
    chk({name, " busy"}, elem_t'(in_ready), 0);
    wait_out(name, lat);
    // lat counts clock edges from the accepting edge to the first out_valid cycle
    chk({name, " latency"}, elem_t'(lat), 3);
    chk({name, " r_out"}, r_out, exp);
    out_ready = 1;
    tick();
    out_ready = 0;
    chk({name, " drained"}, elem_t'(out_valid), 0);
  endtask

  initial begin
    prod_t q[$];
    elem_t held;
    int lat, cyc, got, sent, last;
    logic acc;
    vecs[0] = '{bit_p(409), elem_t'(bit_p(87) | bit_p(0))};
    vecs[1] = '{bit_p(816), elem_t'(bit_p(407) | bit_p(172) | bit_p(85))};
    vecs[2] = '{bit_p(408) | bit_p(0), elem_t'(bit_p(408) | bit_p(0))};
    vecs[3] = '{'0, '0};
    #12;
    chk("reset out_valid", elem_t'(out_valid), 0);
    chk("reset r_out", r_out, '0);
    rst_n = 1;
    tick();
    chk("post-reset in_ready", elem_t'(in_ready), 1);
    chk("post-reset out_valid", elem_t'(out_valid), 0);
    foreach (vecs[i]) run_one($sformatf("vec%0d", i), vecs[i].c, vecs[i].r);

    // back-to-back random stream with both handshakes held high
    in_valid = 1;
    out_ready = 1;
    c_in = rand_p();
    sent = 0;
    got = 0;
    last = -1;
    for (cyc = 0; cyc < 1000 && got < 100; cyc++) begin
      if (out_valid) begin
        chk($sformatf("rand%0d r_out", got), r_out, q.size() ? ref_mod(q.pop_front()) : ~r_out);
        if (last >= 0) chk($sformatf("rand%0d spacing", got), elem_t'(cyc - last), 3);
        last = cyc;
        got++;
      end
      acc = in_ready && in_valid;
      if (acc) begin
        q.push_back(c_in);
        sent++;
      end
      tick();
      if (acc) begin
        if (sent < 100) c_in = rand_p();
        else in_valid = 0;
      end
    end
    chk("rand count", elem_t'(got), 100);
    in_valid = 0;
    out_ready = 0;
    tick();

    // backpressure: hold OUT while a new operand waits
    in_valid = 1;
    c_in = bit_p(409);
    tick();
    in_valid = 0;
    wait_out("bp", lat);
    held = r_out;
    chk("bp first", held, vecs[0].r);
    in_valid = 1;
    c_in = bit_p(816);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp%0d in_ready", i), elem_t'(in_ready), 0);
      chk($sformatf("bp%0d out_valid", i), elem_t'(out_valid), 1);
      chk($sformatf("bp%0d r_out", i), r_out, held);
      tick();
    end
    out_ready = 1;
    #1;
    chk("bp release in_ready", elem_t'(in_ready), 1);
    tick();
    in_valid = 0;
    out_ready = 0;
    chk("bp consumed", elem_t'(out_valid), 0);
    wait_out("bp second", lat);
    chk("bp second latency", elem_t'(lat), 3);
    chk("bp second r_out", r_out, ref_mod(bit_p(816)));

    // reset while holding a result in OUT: out_valid must drop without a clock
    #2;
    rst_n = 0;
    #1;
    chk("rst out out_valid", elem_t'(out_valid), 0);
    chk("rst out r_out", r_out, '0);
    @(posedge clk);
    #1;
    rst_n = 1;
    tick();

    // reset during FOLD1
    run_one("pre-rst", bit_p(816), ref_mod(bit_p(816)));
    in_valid = 1;
    c_in = rand_p();
    tick();
    in_valid = 0;
    #2;
    rst_n = 0;
    #1;
    chk("rst fold1 out_valid", elem_t'(out_valid), 0);
    chk("rst fold1 r_out", r_out, '0);
    tick();
    chk("rst held out_valid", elem_t'(out_valid), 0);
    rst_n = 1;
    tick();
    chk("rst release in_ready", elem_t'(in_ready), 1);
    run_one("post-rst", bit_p(409), vecs[0].r);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
